uart_fifo_ctrl: RTL
===================

# uart_fifo_ctrl

Buffering stage between the CSR-side UART register logic and the `uart_transceiver` bit engine. It decouples software from the serial bit rate in both directions:

- **TX side:** an N-entry TX FIFO is drained one byte at a time into the transceiver's `tx_data`/`tx_wr`, paced by its `tx_done`.
- **RX side:** an N-entry RX FIFO captures every `rx_data`/`rx_done` byte and holds it for the host, with a sticky overrun flag.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4 — FIFO depth is 2^DEPTH_LOG2 entries (16), both directions.
- `WIDTH`, default 8 — data width of each entry.

Ports:
- `sys_clk` in 1 — single clock; one clock; reset is synchronous and active-high.
- `sys_rst` in 1 — synchronous, active-high reset.
- `host_tx_data` in 8 — byte to enqueue.
- `host_tx_wr` in 1 — one-cycle enqueue strobe.
- `tx_full` out 1 — TX FIFO holds DEPTH entries.
- `tx_level` out DEPTH_LOG2+1 — TX occupancy, 0..DEPTH.
- `tx_idle` out 1 — TX FIFO empty and engine in IDLE.
- `xcvr_tx_data` out 8 — byte to transceiver, registered.
- `xcvr_tx_wr` out 1 — one-cycle launch strobe to transceiver, registered.
- `xcvr_tx_done` in 1 — transceiver end-of-frame pulse.
- `xcvr_rx_data` in 8 — received byte.
- `xcvr_rx_done` in 1 — one-cycle received-byte strobe.
- `host_rx_rd` in 1 — one-cycle dequeue strobe.
- `host_rx_data` out 8 — head of RX FIFO (first-word fall-through).
- `rx_empty` out 1 — RX FIFO holds no entries.
- `rx_level` out DEPTH_LOG2+1 — RX occupancy.
- `rx_overrun` out 1 — sticky: a received byte was dropped.
- `rx_overrun_clr` in 1 — clears `rx_overrun`.

## Operation
**Reset values:**
- `tx_full`=0, `tx_level`=0, `tx_idle`=1.
- `xcvr_tx_wr`=0, `xcvr_tx_data`=0.
- `rx_empty`=1, `rx_level`=0, `rx_overrun`=0.
- Both FIFO pointers are 0; the engine is in IDLE.

**TX FIFO:**
- `host_tx_wr` with `!tx_full` pushes `host_tx_data`.
- `host_tx_wr` while `tx_full` is dropped silently; contents are unchanged.

**TX engine** (states IDLE, BUSY):
- IDLE with TX FIFO non-empty: pop the head, load it into `xcvr_tx_data`, pulse `xcvr_tx_wr` for one cycle, then go to BUSY.
- BUSY: wait for `xcvr_tx_done`, then return to IDLE.
- `xcvr_tx_done` seen in IDLE is ignored.
- Consecutive queued bytes therefore go out back-to-back, one launch per `tx_done`.

**RX FIFO:**
- `xcvr_rx_done` with the FIFO not full pushes `xcvr_rx_data`.
- `xcvr_rx_done` when full drops the byte and sets `rx_overrun`. This holds even if `host_rx_rd` is asserted in the same cycle: the push is judged on pre-edge fullness.
- `host_rx_rd` with `!rx_empty` pops.
- `host_rx_rd` while `rx_empty` is ignored; `host_rx_data` is unchanged.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged.
- `rx_overrun_clr` clears the flag; if set and clear occur in the same cycle, set wins.

**Arithmetic:**
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- Level is a separate DEPTH_LOG2+1-bit counter; full is `level==DEPTH`, empty is `level==0`.

## Timing
- `host_tx_wr` in cycle N, FIFO empty, engine IDLE: `tx_level`=1 in N+1, `xcvr_tx_wr` high for exactly cycle N+2 with valid `xcvr_tx_data`, `tx_level`=0 in N+2.
- `xcvr_tx_done` in cycle M with a queued byte: next `xcvr_tx_wr` in cycle M+2.
- `xcvr_rx_done` in cycle N on an empty RX FIFO: `rx_empty`=0 and `host_rx_data` valid in N+1.
- `host_rx_rd` in cycle N: the next head (or `rx_empty`=1) is visible in N+1.
- All status outputs are registered or derived from registered level/pointers; there are no combinational paths from inputs to outputs.
- Reset mid-frame: the engine returns to IDLE and both FIFOs flush in one cycle. A `tx_done` that arrives late after reset is ignored. The transceiver shares `sys_rst`.

## Structure
- Sub-module `uart_sync_fifo` (params WIDTH, DEPTH_LOG2): push, pop, din, dout (FWFT), full, empty, level, with drop-on-full and ignore-on-empty. It is instantiated twice.
- The shared package holds the TX engine state encodings (IDLE=1'b0, BUSY=1'b1) and the default DEPTH_LOG2.
- The engine FSM and overrun flag live in `uart_fifo_ctrl`.

## Test plan
- **Single byte:** write 0x55 with the FIFO empty → `xcvr_tx_wr` pulse 2 cycles later with data 0x55; `tx_idle`=0 until `tx_done`, then 1.
- **TX burst:** write 17 bytes 0x00..0x10 with DEPTH=16 while the engine holds byte 0x00 → `tx_full` asserted and 0x10 accepted only if space exists. Ordering is preserved, and each launch follows a `tx_done` by 2 cycles.
- **RX fill and overrun:** inject 17 `rx_done` bytes 0xA0..0xB0 → `rx_level`=16, `rx_overrun`=1; reads return 0xA0..0xAF and 0xB0 is lost.
- **Simultaneous RX push and pop:** at level 5 → level stays 5. At full with simultaneous push and pop → level 15, overrun set.
- **Overrun set/clear collision:** `rx_overrun_clr` in the same cycle as a dropped push → `rx_overrun` stays 1; a later clear → 0.
- **Reset mid-frame:** `sys_rst` during BUSY with 3 bytes queued → `tx_level`=0, `tx_idle`=1, no further `xcvr_tx_wr`.

Source files
------------

// File: rtl/uart_fifo_ctrl_pkg.sv
// rtl/uart_fifo_ctrl_pkg.sv - shared encodings and defaults for the UART FIFO stage
package uart_fifo_ctrl_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through FIFO, drop-on-full, ignore-on-empty
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LEVEL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [LEVEL_W-1:0]    level_q;
  logic                  do_push;
  logic                  do_pop;

  // Fullness/emptiness come from the separate level counter so pointers can wrap freely.
  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - TX/RX byte buffering between host registers and the UART bit engine
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int WIDTH      = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [WIDTH-1:0]    host_tx_data,
  input  logic                host_tx_wr,
  output logic                tx_full,
  output logic [DEPTH_LOG2:0] tx_level,
  output logic                tx_idle,
  output logic [WIDTH-1:0]    xcvr_tx_data,
  output logic                xcvr_tx_wr,
  input  logic                xcvr_tx_done,
  input  logic [WIDTH-1:0]    xcvr_rx_data,
  input  logic                xcvr_rx_done,
  input  logic                host_rx_rd,
  output logic [WIDTH-1:0]    host_rx_data,
  output logic                rx_empty,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic                rx_overrun,
  input  logic                rx_overrun_clr
);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] tx_head;
  logic             tx_empty;
  logic             tx_pop;
  logic [WIDTH-1:0] xcvr_tx_data_q, xcvr_tx_data_d;
  logic             xcvr_tx_wr_q, xcvr_tx_wr_d;
  logic             rx_full;
  logic             rx_overrun_q, rx_overrun_d;

  uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (host_tx_wr),
    .pop     (tx_pop),
    .din     (host_tx_data),
    .dout    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (xcvr_rx_done),
    .pop     (host_rx_rd),
    .din     (xcvr_rx_data),
    .dout    (host_rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  // TX engine next state: launch the head from IDLE, then hold in BUSY until the frame ends.
  always_comb begin
    state_d        = state_q;
    tx_pop         = 1'b0;
    xcvr_tx_wr_d   = 1'b0;
    xcvr_tx_data_d = xcvr_tx_data_q;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop         = 1'b1;
          xcvr_tx_wr_d   = 1'b1;
          xcvr_tx_data_d = tx_head;
          state_d        = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (xcvr_tx_done) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Overrun flag: a dropped byte (judged on pre-edge fullness) beats a clear in the same cycle.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (rx_overrun_clr)          rx_overrun_d = 1'b0;
    if (xcvr_rx_done && rx_full) rx_overrun_d = 1'b1;
  end

  // Engine state, registered launch outputs and overrun flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= TX_IDLE;
      xcvr_tx_wr_q   <= 1'b0;
      xcvr_tx_data_q <= '0;
      rx_overrun_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      xcvr_tx_wr_q   <= xcvr_tx_wr_d;
      xcvr_tx_data_q <= xcvr_tx_data_d;
      rx_overrun_q   <= rx_overrun_d;
    end
  end

  assign xcvr_tx_wr   = xcvr_tx_wr_q;
  assign xcvr_tx_data = xcvr_tx_data_q;
  assign rx_overrun   = rx_overrun_q;
  assign tx_idle      = tx_empty && (state_q == TX_IDLE);

endmodule
